jk_op_sequencer: RTL

//   Upstream driver for the jk_trigger flip-flop. Accepts one operation request
//   (hold/reset/set/toggle plus repeat count) via a start/busy/done handshake,

---
 rtl/jk_op_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/jk_op_sequencer.sv
// Drives j/k of a downstream jk_trigger for a requested number of clock edges,
// tracks the expected q and flags a disagreement with the fed-back q at the end.
module jk_op_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic             q_in,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             q_exp,
    output logic             mismatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       op_r, op_nx;
    logic [CNT_W-1:0] remaining, remaining_nx;
    logic             j_nx, k_nx, busy_nx, done_nx, q_exp_nx, mismatch_nx;

    always_comb begin
        state_nx     = state;
        op_nx        = op_r;
        remaining_nx = remaining;
        j_nx         = j;
        k_nx         = k;
        busy_nx      = busy;
        done_nx      = 1'b0;
        q_exp_nx     = q_exp;
        mismatch_nx  = mismatch;

        case (state)
            IDLE: begin
                j_nx    = 1'b0;
                k_nx    = 1'b0;
                busy_nx = 1'b0;
                if (start) begin
                    mismatch_nx = 1'b0;
                    q_exp_nx    = q_in;
                    if (count != '0) begin
                        op_nx        = op;
                        remaining_nx = count;
                        j_nx         = op[1];
                        k_nx         = op[0];
                        busy_nx      = 1'b1;
                        state_nx     = DRIVE;
                    end else begin
                        // Zero-length request completes immediately without touching j/k.
                        done_nx = 1'b1;
                    end
                end
            end

            DRIVE: begin
                case (op_r)
                    2'b01:   q_exp_nx = 1'b0;
                    2'b10:   q_exp_nx = 1'b1;
                    2'b11:   q_exp_nx = ~q_exp;
                    default: q_exp_nx = q_exp;
                endcase
                if (remaining != '0) begin
                    remaining_nx = remaining - 1'b1;
                end
                if (remaining <= 1) begin
                    j_nx     = 1'b0;
                    k_nx     = 1'b0;
                    state_nx = CHECK;
                end
            end

            CHECK: begin
                mismatch_nx = (q_in != q_exp);
                done_nx     = 1'b1;
                busy_nx     = 1'b0;
                state_nx    = IDLE;
            end

            default: begin
                j_nx     = 1'b0;
                k_nx     = 1'b0;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_r      <= 2'b00;
            remaining <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            q_exp     <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            state     <= state_nx;
            op_r      <= op_nx;
            remaining <= remaining_nx;
            j         <= j_nx;
            k         <= k_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            q_exp     <= q_exp_nx;
            mismatch  <= mismatch_nx;
        end
    end

endmodule
